// File: rtl/vga_sync_rx_if.sv
// Sync inputs and recovered timing outputs of the VGA sync receiver.
interface vga_sync_rx_if;
   localparam int unsigned CW = 10;

   logic          hsync_in;
   logic          vsync_in;
   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic          vidon;
   logic          locked;
   logic          err;
   logic [CW-1:0] h_total;
   logic [CW-1:0] v_total;

   // Video source side: drives the syncs, observes recovered timing.
   modport master (
      output hsync_in, vsync_in,
      input  hc, vc, vidon, locked, err, h_total, v_total
   );

   // Receiver side.
   modport slave (
      input  hsync_in, vsync_in,
      output hc, vc, vidon, locked, err, h_total, v_total
   );
endinterface

// File: rtl/vga_sync_rx.sv
// Recovers 640x480 VGA pixel/line counters from incoming active-low syncs,
// measures line/frame periods and declares lock after consecutive good frames.
module vga_sync_rx #(
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_TOTAL     = 521,
   parameter int unsigned HBP         = 144,
   parameter int unsigned HFP         = 784,
   parameter int unsigned VBP         = 31,
   parameter int unsigned VFP         = 511,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          clr,
   vga_sync_rx_if.slave  bus
);
   localparam int unsigned CW = 10;
   localparam int unsigned MW = CW + 1;
   localparam int unsigned GW = 4;
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic          err_q, err_d;
   logic          locked_q;

   logic          hs1, hs2, vs1, vs2;
   logic          h_fall, v_fall;
   logic [CW-1:0] hc_q, vc_q, h_total_q, v_total_q;
   logic          line_seen_q, sticky_q;
   logic [MW-1:0] h_meas, v_meas;
   logic          h_bad, h_loss, bad_line, v_bad, frame_bad;

   assign h_fall = hs2 & ~hs1;
   assign v_fall = vs2 & ~vs1;

   assign h_meas = MW'(hc_q) + MW'(1);
   assign v_meas = MW'(vc_q) + MW'(h_fall);

   // A line that ended in saturation was already reported as hsync loss.
   assign h_bad    = h_fall & line_seen_q & (hc_q != CNT_MAX) & (h_meas != MW'(H_TOTAL));
   assign h_loss   = ~h_fall & (hc_q == CNT_MAX - CW'(1));
   assign bad_line = h_bad | h_loss;
   assign v_bad    = v_fall & (v_meas != MW'(V_TOTAL));
   assign frame_bad = v_bad | (v_fall & (sticky_q | bad_line));

   // Sync edge detection, counter recovery and period measurement.
   always_ff @(posedge clk) begin
      if (clr) begin
         hs1         <= 1'b1;
         hs2         <= 1'b1;
         vs1         <= 1'b1;
         vs2         <= 1'b1;
         hc_q        <= '0;
         vc_q        <= '0;
         h_total_q   <= '0;
         v_total_q   <= '0;
         line_seen_q <= 1'b0;
         sticky_q    <= 1'b0;
      end else begin
         hs1 <= bus.hsync_in;
         hs2 <= hs1;
         vs1 <= bus.vsync_in;
         vs2 <= vs1;

         if (h_fall)                hc_q <= '0;
         else if (hc_q != CNT_MAX)  hc_q <= hc_q + CW'(1);

         if (v_fall)                          vc_q <= '0;
         else if (h_fall && vc_q != CNT_MAX)  vc_q <= vc_q + CW'(1);

         if (h_fall) begin
            h_total_q   <= h_meas[MW-1] ? CNT_MAX : h_meas[CW-1:0];
            line_seen_q <= 1'b1;
         end

         if (v_fall) v_total_q <= v_meas[MW-1] ? CNT_MAX : v_meas[CW-1:0];

         if (v_fall)        sticky_q <= 1'b0;
         else if (bad_line) sticky_q <= 1'b1;
      end
   end

   // Lock state register with registered err/locked.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= SEARCH;
         good_q   <= '0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         good_q   <= good_d;
         err_q    <= err_d;
         locked_q <= (state_d == LOCKED);
      end
   end

   // Lock next-state; a frame spoiled only by an earlier, already-reported
   // bad line is discarded without a second err pulse.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_d   = 1'b0;
      case (state_q)
         SEARCH: begin
            if (v_fall) begin
               state_d = TRACK;
               good_d  = '0;
            end
         end
         TRACK: begin
            if (v_fall) begin
               if (frame_bad) begin
                  good_d = '0;
                  err_d  = v_bad | bad_line;
               end else begin
                  good_d = good_q + GW'(1);
                  if (good_q + GW'(1) >= GW'(LOCK_FRAMES)) state_d = LOCKED;
               end
            end else if (bad_line) begin
               err_d = 1'b1;
            end
         end
         LOCKED: begin
            if (bad_line || v_bad) begin
               err_d   = 1'b1;
               state_d = TRACK;
               good_d  = '0;
            end
         end
         default: begin
            state_d = SEARCH;
            good_d  = '0;
         end
      endcase
   end

   assign bus.hc      = hc_q;
   assign bus.vc      = vc_q;
   assign bus.h_total = h_total_q;
   assign bus.v_total = v_total_q;
   assign bus.locked  = locked_q;
   assign bus.err     = err_q;
   assign bus.vidon   = locked_q &
                        (hc_q >= CW'(HBP)) & (hc_q < CW'(HFP)) &
                        (vc_q >= CW'(VBP)) & (vc_q < CW'(VFP));
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator.
- Samples incoming active-low hsync/vsync on the pixel clock and recovers horizontal/vertical pixel counters.
- Measures line and frame periods, checks them against nominal timing, and declares lock after consecutive good frames.
- Provides a gated vidon for downstream capture and pattern-check logic; used for loopback verification and video-input front ends.

Parameters:
- H_TOTAL, 800, expected clocks per line.
- V_TOTAL, 521, expected lines per frame.
- HBP, 144, first active recovered hc (inclusive).
- HFP, 784, end of active hc (exclusive).
- VBP, 31, first active recovered vc (inclusive).
- VFP, 511, end of active vc (exclusive).
- LOCK_FRAMES, 2, consecutive good frames needed for lock (1..15).

Ports:
- clk  in  1  pixel clock; same clock as the source sync.
- clr  in  1  synchronous active-high reset.
- hsync_in  in  1  horizontal sync, active low.
- vsync_in  in  1  vertical sync, active low.
- hc  out  10  recovered horizontal count.
- vc  out  10  recovered vertical count.
- vidon  out  1  active-video flag.
- locked  out  1  timing lock.
- err  out  1  one-cycle pulse on a timing violation.
- h_total  out  10  last measured line period in clocks.
- v_total  out  10  last measured frame period in lines.

Behaviour:
- Interface: one clock, clk; reset clr is synchronous, active-high.
- Reset values:
  - hc = 0, vc = 0, h_total = 0, v_total = 0.
  - locked = 0, err = 0, vidon = 0.
  - State = SEARCH; good-frame counter = 0; line-seen flag = 0.
  - Sync sample registers s1 and s2 = 1, so no false edge is detected after reset.
  - clr asserted mid-frame returns everything to these values on the next edge.
- Edge detect:
  - s1 <= sync_in; s2 <= s1.
  - fall = s2 & ~s1.
  - This gives h_fall and v_fall.
- Horizontal counter:
  - On h_fall: hc <= 0.
  - Otherwise: hc <= hc + 1, saturating at 1023.
  - Latency: hc equals the source hc minus 2.
- Vertical counter:
  - On v_fall: vc <= 0. v_fall has priority, including when simultaneous with h_fall.
  - Else on h_fall: vc <= vc + 1, saturating at 1023.
  - vc can sit at V_TOTAL for a few clocks before v_fall; this is legal because it occurs in blanking.
- Line measurement, on h_fall:
  - h_total <= hc + 1.
  - The line is bad if the line-seen flag is set and hc + 1 != H_TOTAL.
  - The line-seen flag is set by the first h_fall.
- Frame measurement, on v_fall:
  - v_total <= vc + (h_fall ? 1 : 0).
  - The frame is bad if that value != V_TOTAL, or if any bad line occurred since the previous v_fall (sticky flag, cleared on v_fall).
- Loss of hsync: hc reaching 1023 counts as a bad line. The violation is taken once, on the cycle hc becomes 1023.
- State machine:
  - SEARCH:
    - Checks are ignored.
    - On v_fall: go to TRACK with good counter = 0 and the sticky flag cleared.
  - TRACK:
    - Good frame at v_fall: counter + 1. When the counter reaches LOCK_FRAMES, go to LOCKED.
    - Bad frame at v_fall: err pulse, counter = 0, stay in TRACK.
    - Bad line: err pulse in the same cycle as the violation; the frame is marked bad.
  - LOCKED:
    - Bad line or bad frame: err pulse, go to TRACK with counter = 0.
    - locked deasserts on the same edge the err pulse asserts.
- Outputs:
  - locked = (state == LOCKED), registered.
  - vidon is combinational from registers: locked && HBP <= hc < HFP && VBP <= vc < VFP.
  - err is registered, high for exactly one clock per violation event. A bad line and a bad frame on the same cycle produce a single pulse.
- Arithmetic: all counters are 10-bit unsigned. Measurement adds are 11-bit internally, then compared.

Test Plan:
- Clean feed: drive hsync low 96 of 800 clocks and vsync low 2 of 521 lines.
  - h_total = 800 and v_total = 521 after the first frame.
  - locked rises at the third v_fall (SEARCH -> TRACK, then 2 good frames).
  - err never pulses.
- Alignment: once locked, compare hc and vc against the source counters.
  - hc == source hc - 2 throughout.
  - vidon high exactly for hc 144..783 and vc 31..510.
  - vidon count per frame = 640 x 480.
- Line-period error: while locked, shorten one line to 799 clocks.
  - h_total = 799.
  - One err pulse; locked drops that cycle.
  - Relock after 2 further good frames.
- Frame-period error: while locked, send a 520-line frame.
  - v_total = 520, err pulse, locked = 0.
  - vc resets to 0 at v_fall.
- hsync loss: hold hsync high for 2000 clocks while locked.
  - hc saturates at 1023 with a single err pulse.
  - Relock requires 2 good frames after hsync resumes.
- Reset mid-operation: assert clr for 1 cycle mid-frame while locked.
  - All outputs 0 and state SEARCH on the next edge.
  - No spurious err.
  - Lock re-acquired at the third v_fall after reset.
